// File: rtl/npc_seq_ctrl_if.sv
// Sequencer <-> datapath/bus signal bundle; master is the sequencer, slave is the
// datapath, decoder and memory side.
interface npc_seq_ctrl_if #(
  parameter int CNT_W = 64
);
  logic             io_ifu_req;
  logic             io_ifu_resp_valid;
  logic             io_ir_en;
  logic             io_reg_write;
  logic             io_writemem_en;
  logic             io_is_load;
  logic             io_is_ebreak;
  logic             io_illegal;
  logic [4:0]       io_rd;
  logic             io_mem_req;
  logic             io_mem_wen;
  logic             io_mem_resp_valid;
  logic             io_rf_wen;
  logic             io_pc_en;
  logic             io_halt;
  logic [1:0]       io_halt_code;
  logic [2:0]       io_state;
  logic [CNT_W-1:0] io_cycle_cnt;
  logic [CNT_W-1:0] io_instret_cnt;

  modport master (
    output io_ifu_req, io_ir_en, io_mem_req, io_mem_wen, io_rf_wen, io_pc_en,
           io_halt, io_halt_code, io_state, io_cycle_cnt, io_instret_cnt,
    input  io_ifu_resp_valid, io_reg_write, io_writemem_en, io_is_load,
           io_is_ebreak, io_illegal, io_rd, io_mem_resp_valid
  );

  modport slave (
    input  io_ifu_req, io_ir_en, io_mem_req, io_mem_wen, io_rf_wen, io_pc_en,
           io_halt, io_halt_code, io_state, io_cycle_cnt, io_instret_cnt,
    output io_ifu_resp_valid, io_reg_write, io_writemem_en, io_is_load,
           io_is_ebreak, io_illegal, io_rd, io_mem_resp_valid
  );
endinterface

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle core sequencer: 4 cycles per ALU op, 5+ per memory op. Stalls without
// limit on instruction fetch, up to MEM_TMO cycles on data memory before a bus-error halt.
module npc_seq_ctrl #(
  parameter int CNT_W   = 64,
  parameter int MEM_TMO = 255
) (
  input logic            clock,
  input logic            reset,
  npc_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  // Counter only ever holds 0..MEM_TMO-1: the last value either completes or times out.
  localparam int WAIT_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TMO - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]       halt_code;
  logic [1:0]       halt_code_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  logic ifu_req;
  logic ir_en;
  logic mem_req;
  logic mem_wen;
  logic rf_wen;
  logic pc_en;
  logic halt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      halt_code   <= 2'd0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state     <= state_nxt;
      halt_code <= halt_code_nxt;
      if (state != MEM) begin
        wait_cnt <= '0;
      end else if (!bus.io_mem_resp_valid) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (state != HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (state == WB) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    halt_code_nxt = halt_code;
    ifu_req       = 1'b0;
    ir_en         = 1'b0;
    mem_req       = 1'b0;
    mem_wen       = 1'b0;
    rf_wen        = 1'b0;
    pc_en         = 1'b0;
    halt          = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        ifu_req = 1'b1;
        if (bus.io_ifu_resp_valid) begin
          ir_en     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        // Illegal takes priority so a malformed ebreak encoding reports as illegal.
        if (bus.io_illegal) begin
          state_nxt     = HALT;
          halt_code_nxt = 2'd1;
        end else if (bus.io_is_ebreak) begin
          state_nxt     = HALT;
          halt_code_nxt = 2'd0;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = (bus.io_is_load || bus.io_writemem_en) ? MEM : WB;
      MEM: begin
        mem_req = 1'b1;
        mem_wen = bus.io_writemem_en;
        if (bus.io_mem_resp_valid) begin
          state_nxt = WB;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt     = HALT;
          halt_code_nxt = 2'd2;
        end
      end
      WB: begin
        pc_en     = 1'b1;
        rf_wen    = bus.io_reg_write && (bus.io_rd != 5'd0);
        state_nxt = FETCH;
      end
      HALT: halt = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.io_ifu_req     = ifu_req;
  assign bus.io_ir_en       = ir_en;
  assign bus.io_mem_req     = mem_req;
  assign bus.io_mem_wen     = mem_wen;
  assign bus.io_rf_wen      = rf_wen;
  assign bus.io_pc_en       = pc_en;
  assign bus.io_halt        = halt;
  assign bus.io_halt_code   = halt_code;
  assign bus.io_state       = state;
  assign bus.io_cycle_cnt   = cycle_cnt;
  assign bus.io_instret_cnt = instret_cnt;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Bench for npc_seq_ctrl: per-cycle vector table, directed halt/reset sequences and
// randomized instruction streams checked against an instruction-level timing model.
module tb_npc_seq_ctrl;
  localparam int CNT_W   = 64;
  localparam int MEM_TMO = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  npc_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();
  npc_seq_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks     = 0;
  int failures   = 0;
  int cyc_model  = 0;
  int inst_model = 0;

  // ins  = {ifu_resp_valid, mem_resp_valid, reg_write, writemem_en, is_load, is_ebreak, illegal}
  // outs = {ifu_req, ir_en, mem_req, mem_wen, rf_wen, pc_en, halt}
  typedef struct {
    logic [6:0] ins;
    logic [4:0] rd;
    logic [2:0] st;
    logic [6:0] outs;
    logic [1:0] code;
    int         cyc;
    int         inst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [6:0] ins, logic [4:0] rd, logic [2:0] st,
                              logic [6:0] outs, logic [1:0] code, int cyc, int inst);
    vec_t v;
    v.ins = ins; v.rd = rd; v.st = st; v.outs = outs;
    v.code = code; v.cyc = cyc; v.inst = inst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_dec(input logic rw, input logic wm, input logic ld,
                         input logic eb, input logic il, input logic [4:0] rd);
    bus.io_reg_write   = rw;
    bus.io_writemem_en = wm;
    bus.io_is_load     = ld;
    bus.io_is_ebreak   = eb;
    bus.io_illegal     = il;
    bus.io_rd          = rd;
  endtask

  // Every helper leaves time at 1ns after a rising edge.
  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic half(input logic ifu, input logic mem);
    bus.io_ifu_resp_valid = ifu;
    bus.io_mem_resp_valid = mem;
    @(negedge clock);
  endtask

  task automatic rel_reset();
    reset = 1'b0;
    bus.io_ifu_resp_valid = 1'b0;
    bus.io_mem_resp_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset      = 1'b1;
    cyc_model  = 0;
    inst_model = 0;
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store; f/m = extra wait cycles before each response.
  task automatic run_instr(input int kind, input int f, input int m,
                           input logic [4:0] rd, input logic rw);
    int  fc, mc, irc, mrq, mwn, rfw, n, first, memc, lat;
    bit  done;
    fc = 0; mc = 0; irc = 0; mrq = 0; mwn = 0; rfw = 0; n = 0; first = -1; done = 0;
    memc = (kind != 0) ? m + 1 : 0;
    lat  = (f + 1) + 2 + memc + 1;
    set_dec(rw, kind == 2, kind == 1, 1'b0, 1'b0, rd);
    while (!done && n < 40) begin
      if (bus.io_ifu_req) begin
        fc++;
        if (first < 0) first = n;
        bus.io_ifu_resp_valid = (fc == f + 1);
      end else begin
        bus.io_ifu_resp_valid = 1'($urandom_range(0, 1));
      end
      if (bus.io_mem_req) begin
        mc++;
        bus.io_mem_resp_valid = (mc == m + 1);
      end else begin
        bus.io_mem_resp_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      irc += int'(bus.io_ir_en);
      mrq += int'(bus.io_mem_req);
      mwn += int'(bus.io_mem_wen);
      rfw += int'(bus.io_rf_wen);
      if (bus.io_pc_en) begin
        done = 1;
        chk("rnd latency", n - first + 1, lat);
        chk("rnd wb state", bus.io_state, 5);
        chk("rnd cycle_cnt", bus.io_cycle_cnt, cyc_model);
        chk("rnd instret", bus.io_instret_cnt, inst_model);
        chk("rnd ir_en pulses", irc, 1);
        chk("rnd mem_req cycles", mrq, memc);
        chk("rnd mem_wen cycles", mwn, (kind == 2) ? m + 1 : 0);
        chk("rnd rf_wen", rfw, (rw && rd != 5'd0) ? 1 : 0);
      end
      adv();
      cyc_model++;
      n++;
    end
    chk("rnd wb reached", done, 1);
    inst_model++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // addi rd=5, addi rd=0 after a fetch stall, store with 3 wait cycles, illegal+ebreak.
    tbl.push_back(mk(7'b1010000, 5'd5, 3'd0, 7'b0000000, 2'd0,  0, 0));
    tbl.push_back(mk(7'b1010000, 5'd5, 3'd1, 7'b1100000, 2'd0,  1, 0));
    tbl.push_back(mk(7'b0010000, 5'd5, 3'd2, 7'b0000000, 2'd0,  2, 0));
    tbl.push_back(mk(7'b0110000, 5'd5, 3'd3, 7'b0000000, 2'd0,  3, 0));
    tbl.push_back(mk(7'b0010000, 5'd5, 3'd5, 7'b0000110, 2'd0,  4, 0));
    tbl.push_back(mk(7'b0010000, 5'd5, 3'd1, 7'b1000000, 2'd0,  5, 1));
    tbl.push_back(mk(7'b1010000, 5'd0, 3'd1, 7'b1100000, 2'd0,  6, 1));
    tbl.push_back(mk(7'b0010000, 5'd0, 3'd2, 7'b0000000, 2'd0,  7, 1));
    tbl.push_back(mk(7'b0010000, 5'd0, 3'd3, 7'b0000000, 2'd0,  8, 1));
    tbl.push_back(mk(7'b0010000, 5'd0, 3'd5, 7'b0000010, 2'd0,  9, 1));
    tbl.push_back(mk(7'b1001000, 5'd3, 3'd1, 7'b1100000, 2'd0, 10, 2));
    tbl.push_back(mk(7'b0001000, 5'd3, 3'd2, 7'b0000000, 2'd0, 11, 2));
    tbl.push_back(mk(7'b0101000, 5'd3, 3'd3, 7'b0000000, 2'd0, 12, 2));
    tbl.push_back(mk(7'b0001000, 5'd3, 3'd4, 7'b0011000, 2'd0, 13, 2));
    tbl.push_back(mk(7'b0001000, 5'd3, 3'd4, 7'b0011000, 2'd0, 14, 2));
    tbl.push_back(mk(7'b0001000, 5'd3, 3'd4, 7'b0011000, 2'd0, 15, 2));
    tbl.push_back(mk(7'b0101000, 5'd3, 3'd4, 7'b0011000, 2'd0, 16, 2));
    tbl.push_back(mk(7'b0001000, 5'd3, 3'd5, 7'b0000010, 2'd0, 17, 2));
    tbl.push_back(mk(7'b1000011, 5'd0, 3'd1, 7'b1100000, 2'd0, 18, 3));
    tbl.push_back(mk(7'b0000011, 5'd0, 3'd2, 7'b0000000, 2'd0, 19, 3));
    tbl.push_back(mk(7'b1100011, 5'd0, 3'd6, 7'b0000001, 2'd1, 20, 3));
    for (int j = 0; j < 10; j++) begin
      tbl.push_back(mk(7'b1100000, 5'd0, 3'd6, 7'b0000001, 2'd1, 20, 3));
    end

    rel_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      {bus.io_ifu_resp_valid, bus.io_mem_resp_valid, bus.io_reg_write, bus.io_writemem_en,
       bus.io_is_load, bus.io_is_ebreak, bus.io_illegal} = tbl[i].ins;
      bus.io_rd = tbl[i].rd;
      @(negedge clock);
      chk($sformatf("row%0d state", i), bus.io_state, tbl[i].st);
      chk($sformatf("row%0d enables", i),
          {bus.io_ifu_req, bus.io_ir_en, bus.io_mem_req, bus.io_mem_wen,
           bus.io_rf_wen, bus.io_pc_en, bus.io_halt}, tbl[i].outs);
      chk($sformatf("row%0d halt_code", i), bus.io_halt_code, tbl[i].code);
      chk($sformatf("row%0d cycle_cnt", i), bus.io_cycle_cnt, tbl[i].cyc);
      chk($sformatf("row%0d instret", i), bus.io_instret_cnt, tbl[i].inst);
      adv();
    end

    // ebreak alone halts with code 0; reset must have cleared the previous code 1.
    rel_reset();
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    half(1'b1, 1'b0); adv();
    half(1'b1, 1'b0); adv();
    half(1'b0, 1'b0); adv();
    half(1'b0, 1'b0);
    chk("ebreak state", bus.io_state, 6);
    chk("ebreak halt", bus.io_halt, 1);
    chk("ebreak code", bus.io_halt_code, 0);
    chk("ebreak pc_en", bus.io_pc_en, 0);

    // Load with no response times out after exactly MEM_TMO cycles in MEM.
    rel_reset();
    set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    half(1'b1, 1'b0); adv();
    half(1'b1, 1'b0); adv();
    half(1'b0, 1'b0); adv();
    half(1'b0, 1'b0); adv();
    repeat (3) begin half(1'b0, 1'b0); adv(); end
    half(1'b0, 1'b0);
    chk("tmo last mem state", bus.io_state, 4);
    chk("tmo last mem req", bus.io_mem_req, 1);
    adv();
    half(1'b0, 1'b1);
    chk("tmo halt state", bus.io_state, 6);
    chk("tmo halt code", bus.io_halt_code, 2);
    chk("tmo mem_req drop", bus.io_mem_req, 0);
    chk("tmo halt", bus.io_halt, 1);
    chk("tmo cycle_cnt", bus.io_cycle_cnt, 8);
    adv();
    half(1'b0, 1'b0);
    chk("tmo late resp state", bus.io_state, 6);
    chk("tmo cycle frozen", bus.io_cycle_cnt, 8);

    // Reset pulse in the middle of a store's MEM wait; late response must be ignored.
    rel_reset();
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2);
    half(1'b0, 1'b0);
    chk("rst halt cleared", bus.io_halt, 0);
    chk("rst code cleared", bus.io_halt_code, 0);
    adv();
    half(1'b1, 1'b0); adv();
    half(1'b0, 1'b0); adv();
    half(1'b0, 1'b0); adv();
    half(1'b0, 1'b0); adv();
    reset = 1'b0;
    half(1'b0, 1'b0);
    chk("rst pre state", bus.io_state, 4);
    adv();
    reset = 1'b1;
    half(1'b0, 1'b1);
    chk("rst state idle", bus.io_state, 0);
    chk("rst cycle_cnt", bus.io_cycle_cnt, 0);
    chk("rst instret", bus.io_instret_cnt, 0);
    chk("rst mem_req", bus.io_mem_req, 0);
    adv();
    half(1'b0, 1'b1);
    chk("rst late resp state", bus.io_state, 1);
    chk("rst late resp mem_req", bus.io_mem_req, 0);
    adv();
    half(1'b0, 1'b0);
    chk("rst fetch waits", bus.io_state, 1);

    // Randomized instruction stream.
    rel_reset();
    for (int i = 0; i < 150; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, MEM_TMO - 1),
                rd, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
